// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution
// partial-sum engine.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  // Issue -> operand fetch -> result register.
  localparam int PIPE_DEPTH = 2;

  // Clamp a wide signed value into a dw-bit signed range.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Pixel/channel/kernel loop counters and the
// activation address and weight index they imply.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int DIM_W  = 12,
  parameter int ADDR_W = 16,
  parameter int WIDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [DIM_W-1:0]  ch,
  input  logic [DIM_W-1:0]  width,
  input  logic [2:0]        ksize,
  input  logic [2:0]        stride,
  output logic [ADDR_W-1:0] a_addr,
  output logic [WIDX_W-1:0] w_idx,
  output logic              first,
  output logic              last_term,
  output logic              last_frame
);

  localparam int XW = DIM_W + 2;

  logic [2:0]        kx;
  logic [2:0]        ky;
  logic [DIM_W-1:0]  c;
  logic [DIM_W-1:0]  ox;
  logic [DIM_W-1:0]  oy;
  logic [WIDX_W-1:0] widx;

  logic kx_end;
  logic ky_end;
  logic c_end;
  logic x_end;
  logic y_end;
  logic [ADDR_W-1:0] plane;

  // ox/oy hold the window origin, so the row test
  // needs no division by stride.
  always_comb begin
    kx_end = (kx == ksize - 3'd1);
    ky_end = (ky == ksize - 3'd1);
    c_end  = (c == ch - DIM_W'(1));
    x_end  = (XW'(ox) + XW'(stride) + XW'(ksize))
             > XW'(width);
    y_end  = (XW'(oy) + XW'(stride) + XW'(ksize))
             > XW'(width);
    plane  = ADDR_W'(width) * ADDR_W'(width);
    a_addr = ADDR_W'(c) * plane
           + (ADDR_W'(oy) + ADDR_W'(ky))
             * ADDR_W'(width)
           + ADDR_W'(ox) + ADDR_W'(kx);
    w_idx      = widx;
    first      = (kx == 3'd0) && (ky == 3'd0)
                 && (c == '0);
    last_term  = kx_end && ky_end && c_end;
    last_frame = last_term && x_end && y_end;
  end

  // Advance kx, ky, c, then the output pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx   <= '0;
      ky   <= '0;
      c    <= '0;
      ox   <= '0;
      oy   <= '0;
      widx <= '0;
    end else if (clr) begin
      kx   <= '0;
      ky   <= '0;
      c    <= '0;
      ox   <= '0;
      oy   <= '0;
      widx <= '0;
    end else if (step) begin
      widx <= last_term ? '0 : widx + WIDX_W'(1);
      if (!kx_end) begin
        kx <= kx + 3'd1;
      end else begin
        kx <= '0;
        if (!ky_end) begin
          ky <= ky + 3'd1;
        end else begin
          ky <= '0;
          if (!c_end) begin
            c <= c + DIM_W'(1);
          end else begin
            c <= '0;
            if (x_end) begin
              ox <= '0;
              oy <= oy + DIM_W'(stride);
            end else begin
              ox <= ox + DIM_W'(stride);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_psum_engine.sv
// Multi-lane convolution engine: loads a weight set,
// then sweeps output pixels producing saturated sums.
module conv_psum_engine
  import conv_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int N_LANE     = 4,
  parameter int DIM_W      = 12,
  parameter int ADDR_W     = 16,
  parameter int K_MAX      = 5,
  parameter int WBUF_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     addr_rst,
  input  logic [DIM_W-1:0]         cfg_channel,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [2:0]               cfg_ksize,
  input  logic [2:0]               cfg_stride,
  input  logic [4:0]               cfg_shift,
  input  logic                     load_weight_start,
  output logic                     w_rd_en,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic [N_LANE*DATA_W-1:0] w_data,
  output logic                     weight_done,
  input  logic                     init_signal,
  output logic                     a_rd_en,
  output logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  output logic [N_LANE*DATA_W-1:0] out_psum,
  output logic                     out_psum_vld,
  output logic                     frame_done,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int WIDX_W = $clog2(WBUF_DEPTH);
  localparam int LW     = N_LANE * DATA_W;

  state_t state;
  logic   weights_valid;

  logic [DIM_W-1:0]  c_ch;
  logic [DIM_W-1:0]  c_w;
  logic [2:0]        c_k;
  logic [2:0]        c_s;
  logic [4:0]        c_sh;

  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] wtot;
  logic              wr_vld;
  logic              wr_last;
  logic [WIDX_W-1:0] wr_idx;

  logic [LW-1:0]     wbuf [WBUF_DEPTH];
  logic [LW-1:0]     wbuf_q;

  logic p1_vld;
  logic p1_first;
  logic p1_last;
  logic p1_end;

  logic signed [ACC_W-1:0] acc    [N_LANE];
  logic signed [ACC_W-1:0] acc_nx [N_LANE];
  logic [LW-1:0]           psum_nx;

  logic [WIDX_W-1:0] ag_widx;
  logic              ag_first;
  logic              ag_last;
  logic              ag_end;
  logic              ag_clr;

  logic [31:0] cfg_tot;
  logic        cfg_bad;

  // Start-time legality of the presented config.
  always_comb begin
    cfg_tot = 32'(cfg_ksize) * 32'(cfg_ksize)
            * 32'(cfg_channel);
    cfg_bad = (cfg_ksize == 3'd0)
           || (32'(cfg_ksize) > 32'(K_MAX))
           || (cfg_stride == 3'd0)
           || (cfg_channel == '0)
           || (cfg_width < DIM_W'(cfg_ksize))
           || (cfg_tot > 32'(WBUF_DEPTH));
  end

  assign busy    = (state != S_IDLE);
  assign w_addr  = wcnt;
  assign w_rd_en = (state == S_LOAD_W) && en
                   && (wcnt < wtot);
  assign a_rd_en = (state == S_COMPUTE) && en;
  assign ag_clr  = addr_rst || (state == S_IDLE);

  conv_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W),
    .WIDX_W (WIDX_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (ag_clr),
    .step       (a_rd_en),
    .ch         (c_ch),
    .width      (c_w),
    .ksize      (c_k),
    .stride     (c_s),
    .a_addr     (a_addr),
    .w_idx      (ag_widx),
    .first      (ag_first),
    .last_term  (ag_last),
    .last_frame (ag_end)
  );

  // Weight RAM: delayed write, registered read.
  always_ff @(posedge clk) begin
    if (wr_vld) wbuf[wr_idx] <= w_data;
    wbuf_q <= wbuf[ag_widx];
  end

  // Per-lane MAC on the fetched operands and the
  // saturated result it would produce.
  always_comb begin
    logic signed [DATA_W-1:0]   wl;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shv;
    psum_nx = '0;
    for (int l = 0; l < N_LANE; l++) begin
      wl   = wbuf_q[l*DATA_W +: DATA_W];
      prod = $signed(a_data) * wl;
      acc_nx[l] = p1_first
                ? ACC_W'(prod)
                : acc[l] + ACC_W'(prod);
      shv = acc_nx[l] >>> c_sh;
      psum_nx[l*DATA_W +: DATA_W] =
        DATA_W'(saturate(64'(shv), DATA_W));
    end
  end

  // Control FSM, load/compute pipeline and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      weights_valid <= 1'b0;
      c_ch          <= '0;
      c_w           <= '0;
      c_k           <= '0;
      c_s           <= '0;
      c_sh          <= '0;
      wcnt          <= '0;
      wtot          <= '0;
      wr_vld        <= 1'b0;
      wr_last       <= 1'b0;
      wr_idx        <= '0;
      p1_vld        <= 1'b0;
      p1_first      <= 1'b0;
      p1_last       <= 1'b0;
      p1_end        <= 1'b0;
      weight_done   <= 1'b0;
      out_psum_vld  <= 1'b0;
      frame_done    <= 1'b0;
      cfg_err       <= 1'b0;
      out_psum      <= '0;
      for (int l = 0; l < N_LANE; l++)
        acc[l] <= '0;
    end else begin
      weight_done  <= 1'b0;
      out_psum_vld <= 1'b0;
      frame_done   <= 1'b0;
      cfg_err      <= 1'b0;
      if (addr_rst) begin
        if (state == S_LOAD_W)
          weights_valid <= 1'b0;
        state    <= S_IDLE;
        wcnt     <= '0;
        wr_vld   <= 1'b0;
        wr_last  <= 1'b0;
        p1_vld   <= 1'b0;
        p1_first <= 1'b0;
        p1_last  <= 1'b0;
        p1_end   <= 1'b0;
      end else begin
        p1_vld   <= a_rd_en;
        p1_first <= ag_first;
        p1_last  <= ag_last;
        p1_end   <= ag_end;
        wr_vld   <= w_rd_en;
        wr_last  <= w_rd_en
                    && (wcnt == wtot - ADDR_W'(1));
        wr_idx   <= wcnt[WIDX_W-1:0];
        unique case (state)
          S_IDLE: begin
            if (load_weight_start) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                state         <= S_LOAD_W;
                weights_valid <= 1'b0;
                wcnt          <= '0;
                wtot          <= ADDR_W'(cfg_tot);
                c_ch          <= cfg_channel;
                c_w           <= cfg_width;
                c_k           <= cfg_ksize;
                c_s           <= cfg_stride;
                c_sh          <= cfg_shift;
              end
            end else if (init_signal) begin
              if (cfg_bad || !weights_valid) begin
                cfg_err <= 1'b1;
              end else begin
                state <= S_COMPUTE;
                c_ch  <= cfg_channel;
                c_w   <= cfg_width;
                c_k   <= cfg_ksize;
                c_s   <= cfg_stride;
                c_sh  <= cfg_shift;
              end
            end
          end
          S_LOAD_W: begin
            if (w_rd_en) wcnt <= wcnt + ADDR_W'(1);
            if (wr_vld && wr_last) begin
              weight_done   <= 1'b1;
              weights_valid <= 1'b1;
              state         <= S_IDLE;
            end
          end
          S_COMPUTE: begin
            if (a_rd_en && ag_end) state <= S_DRAIN;
          end
          S_DRAIN: ;
          default: state <= S_IDLE;
        endcase
        if (p1_vld) begin
          for (int l = 0; l < N_LANE; l++)
            acc[l] <= acc_nx[l];
          if (p1_last) begin
            out_psum_vld <= 1'b1;
            out_psum     <= psum_nx;
          end
          if (p1_end) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: doc/conv_psum_engine.md
CONV_PSUM_ENGINE -- requirements
Module: conv_psum_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning activation/weight/output element width (signed).
REQ-002 SHALL have parameter ACC_W, default 24, meaning per-lane accumulator width (signed).
REQ-003 SHALL have parameter N_LANE, default 4, meaning filters computed in parallel.
REQ-004 SHALL have parameters DIM_W 12 (config field width), ADDR_W 16 (memory address width), K_MAX 5 (largest kernel side), WBUF_DEPTH 256 (weight words per lane).
REQ-005 SHALL have ports, in order:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 en  in  1  issue enable
 addr_rst  in  1  synchronous abort to IDLE
 cfg_channel, cfg_width  in  DIM_W  input channels; square input side
 cfg_ksize, cfg_stride  in  3  kernel side; stride
 cfg_shift  in  5  arithmetic right shift before saturation
 load_weight_start  in  1  start weight load
 w_rd_en, w_addr  out  1, ADDR_W  weight memory read
 w_data  in  N_LANE*DATA_W  weight data, lane 0 in LSBs, 1-cycle read latency
 weight_done  out  1  one-cycle pulse, load finished
 init_signal  in  1  start computation
 a_rd_en, a_addr  out  1, ADDR_W  activation memory read
 a_data  in  DATA_W  activation, 1-cycle read latency
 out_psum  out  N_LANE*DATA_W  results, lane 0 in LSBs
 out_psum_vld, frame_done, cfg_err  out  1  one-cycle pulses
 busy  out  1  high when state is not IDLE

Function
REQ-006 SHALL implement states IDLE, LOAD_W, COMPUTE, DRAIN; a weights_valid flag qualifies stored weights.
REQ-007 SHALL latch all cfg_* inputs on an accepted start; cfg changes mid-phase SHALL have no effect.
REQ-008 SHALL reject a start (cfg_err pulse next cycle, stay IDLE) if ksize=0, ksize>K_MAX, stride=0, channel=0, width<ksize, or ksize*ksize*channel>WBUF_DEPTH.
REQ-009 In IDLE, load_weight_start SHALL enter LOAD_W, clear weights_valid, and issue w_addr=0..T-1 (T=ksize*ksize*channel) one per cycle while en=1.
REQ-010 Each w_data word SHALL be written to the internal buffer one cycle after its read; weight_done and weights_valid SHALL assert the cycle after the last write, then IDLE.
REQ-011 In IDLE, init_signal with weights_valid=0 SHALL pulse cfg_err; with weights_valid=1 and valid cfg it SHALL enter COMPUTE.
REQ-012 COMPUTE SHALL sweep OW*OW output pixels, OW=(width-ksize)/stride+1, row-major; per pixel, loops c (outer), ky, kx (inner).
REQ-013 a_addr SHALL equal c*width*width + (oy*stride+ky)*width + (ox*stride+kx), truncated to ADDR_W; the weight index SHALL be (c*ksize+ky)*ksize+kx.
REQ-014 Per term, each lane SHALL compute acc += a_data*w (signed, full-precision product sign-extended to ACC_W, wrap on overflow); the first term of a pixel SHALL load rather than add.
REQ-015 out_psum lane SHALL equal saturate_to_DATA_W(acc >>> cfg_shift), clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-016 If a pixel's last read issues in cycle t, out_psum_vld SHALL be high in cycle t+2 only; consecutive pixels SHALL issue back-to-back with no bubbles.
REQ-017 en=0 SHALL suspend new reads (rd_en low, counters held); in-flight terms SHALL complete unchanged.
REQ-018 After the final read, the block SHALL enter DRAIN; frame_done SHALL pulse together with the last out_psum_vld, then IDLE.
REQ-019 load_weight_start during LOAD_W/COMPUTE/DRAIN and init_signal outside IDLE SHALL be ignored; if both are high in IDLE, load_weight_start SHALL win.
REQ-020 addr_rst SHALL override all starts and, next cycle, force IDLE, clear counters and pipeline valids, and emit no further pulses; weights_valid SHALL be cleared only if aborting LOAD_W.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, weights_valid=0, all rd_en/pulse outputs 0, a_addr=w_addr=0, out_psum=0; buffer contents undefined.
REQ-022 Reset SHALL be released synchronously to clk and SHALL be honoured mid-operation.

Structure
REQ-023 State encoding, pipeline-depth constant (2) and the saturate function SHALL live in shared package conv_pkg.
REQ-024 Loop counters and address arithmetic SHALL be one sub-module, conv_addr_gen; the weight buffer SHALL be inferable RAM.

Verification
REQ-025 ch=4, width=5, k=3, stride=1, shift=0, all weights/acts=1 -> 9 vld pulses, every lane=36, frame_done with the 9th.
REQ-026 Same cfg, weights and acts=127 -> every lane saturates to 127; weights=-127 -> -128.
REQ-027 width=5, k=3, stride=2 -> 4 outputs; first-pixel a_addr sequence starts 0,1,2,5,6,7,10,11,12,25.
REQ-028 init_signal before any load -> cfg_err one pulse, busy stays 0; k=3, ch=29 (261>256) load -> cfg_err.
REQ-029 en low 5 cycles mid-pixel -> identical results, vld delayed exactly 5 cycles.
REQ-030 addr_rst mid-COMPUTE then init_signal -> no stale vld, full 9-output frame, weights retained; rst_n low mid-LOAD_W -> weights_valid=0.
